wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: count of consecutive cycles a pending FPU/VPU write may lose the port to the pipeline before hold is raised; legal range 2..15.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 pipe_we_i  in  1  in-order pipeline GPR write request; always granted, with no backpressure.
REQ-005 pipe_fwe_i  in  1  in-order pipeline FPR write request; mutually exclusive with pipe_we_i.
REQ-006 pipe_rd_i  in  5 (REG_t)  pipeline destination index.
REQ-007 pipe_data_i  in  32  pipeline write data.
REQ-008 fpu_valid_i / fpu_ready_o  in/out  1/1  multi-cycle FPU result handshake.
REQ-009 fpu_fp_i  in  1  FPU destination is the FPR file (1) or the GPR file (0).
REQ-010 fpu_rd_i, fpu_data_i  in  5, 32  FPU destination index and data.
REQ-011 vpu_valid_i / vpu_ready_o  in/out  1/1  vector-unit scalar result handshake; destination is always a GPR.
REQ-012 vpu_rd_i, vpu_data_i  in  5, 32  VPU destination index and data.
REQ-013 wb_rd_web_o, wb_frd_web_o  out  1, 1  registered GPR and FPR write enables to the register files.
REQ-014 wb_rd_o, wb_data_o  out  5, 32  registered write index and data.
REQ-015 wb_hold_o  out  1  registered request for the pipeline to freeze its WB producer.
REQ-016 id_rs1_i, id_rs2_i, id_rs3_i, id_use_fpr_i  in  5, 5, 5, 3  ID-stage source indices and FPR-use flags, with bit [2]=rs1, bit [1]=rs2, bit [0]=rs3.
REQ-017 id_rs1_forward_o, id_rs2_forward_o, id_rs3_forward_o  out  1 each  forward-select outputs to ID.

Function
REQ-018 Port grant priority per cycle: the pipeline has the port when wb_hold_o=0 and (pipe_we_i|pipe_fwe_i); otherwise the FPU/VPU winner per REQ-019 has it.
REQ-019 FPU/VPU selection: when both are valid, rr_q picks the winner (0 selects FPU, 1 selects VPU); when only one is valid, that one wins regardless of rr_q.
REQ-020 A grant to FPU or VPU sets rr_q to point at the other requester; rr_q is otherwise unchanged.
REQ-021 Handshakes: fpu_ready_o and vpu_ready_o are combinational; each is 1 only in the cycle its requester is granted. A transfer occurs when valid&ready.
REQ-022 valid is held with its payload stable until the transfer occurs; the arbiter holds no result storage.
REQ-023 Output latency is exactly one cycle: the granted request's enables, index and data appear on wb_* in the cycle after the grant.
REQ-024 With no grant, both enables are 0 next cycle, and wb_rd_o/wb_data_o hold their previous values.
REQ-025 Any GPR write with index 0 drives wb_rd_web_o=0 (discarded), but still counts as a grant and a handshake.
REQ-026 starve_cnt_q (4 bits) increments in each cycle where (fpu_valid_i|vpu_valid_i) is set and the pipeline takes the port.
REQ-027 starve_cnt_q clears to 0 on any FPU/VPU grant, and holds otherwise.
REQ-028 wb_hold_o sets on the edge where starve_cnt_q == STARVE_MAX-1 and the pipeline again takes the port while FPU/VPU is pending.
REQ-029 wb_hold_o clears on the edge following the first FPU/VPU grant after it was set.
REQ-030 While wb_hold_o=1, a pipeline write request is a protocol violation: it is ignored, and the bench asserts that it never occurs.
REQ-031 Forwarding: id_rsN_forward_o=1 iff the matching registered enable is set and wb_rd_o == id_rsN_i.
REQ-032 The "matching" enable is wb_frd_web_o when id_use_fpr_i selects the FPR file and wb_rd_web_o otherwise; rs3 always uses wb_frd_web_o.
REQ-033 Forwarding outputs are combinational from registered state and ID inputs.

Reset
REQ-034 While rst_i=1, asynchronously: wb_rd_web_o=0, wb_frd_web_o=0, wb_rd_o=0, wb_data_o=0, wb_hold_o=0, rr_q=0, starve_cnt_q=0.
REQ-035 During reset, fpu_ready_o=vpu_ready_o=0 and all forward outputs are 0.
REQ-036 Reset asserted mid-handshake aborts the grant: no write appears after reset release, and the requester re-presents its result.

Verification
REQ-037 Pipe GPR write rd=5, data=0xDEADBEEF -> next cycle wb_rd_web_o=1, wb_rd_o=5, wb_data_o=0xDEADBEEF; with id_rs1_i=5 and use_fpr[2]=0, id_rs1_forward_o=1.
REQ-038 FPU and VPU both valid from reset with no pipe traffic -> grants go FPU, VPU, FPU on consecutive cycles; a single ready is asserted in each cycle.
REQ-039 VPU valid with pipe writing every cycle, STARVE_MAX=4 -> wb_hold_o rises after 4 lost cycles; VPU is granted the next cycle; wb_hold_o falls one cycle later; starve_cnt_q=0.
REQ-040 FPU result fp=1, rd=3 while ID reads GPR x3 -> wb_frd_web_o=1, wb_rd_web_o=0, id_rs1_forward_o=0.
REQ-041 VPU write to x0 -> vpu_ready_o=1 and the handshake completes, with wb_rd_web_o=0 next cycle.
REQ-042 rst_i pulsed asynchronously mid-cycle while wb_hold_o=1 and FPU is valid -> all outputs read 0 immediately; after release the FPU is granted first (rr_q=0).

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write-back port between the in-order pipeline and the
// FPU/VPU result handshakes, with a starvation hold and ID-stage forwarding.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_we_i,
    input  logic        pipe_fwe_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        fpu_valid_i,
    output logic        fpu_ready_o,
    input  logic        fpu_fp_i,
    input  logic [4:0]  fpu_rd_i,
    input  logic [31:0] fpu_data_i,
    input  logic        vpu_valid_i,
    output logic        vpu_ready_o,
    input  logic [4:0]  vpu_rd_i,
    input  logic [31:0] vpu_data_i,
    output logic        wb_rd_web_o,
    output logic        wb_frd_web_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_hold_o,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rs3_i,
    input  logic [2:0]  id_use_fpr_i,
    output logic        id_rs1_forward_o,
    output logic        id_rs2_forward_o,
    output logic        id_rs3_forward_o
);
    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    logic        r_rr;
    logic [3:0]  r_starve_cnt;

    logic        w_pipe_grant;
    logic        w_fpu_pick;
    logic        w_vpu_pick;
    logic        w_fpu_grant;
    logic        w_vpu_grant;
    logic        w_pending;
    logic        w_gpr_we;
    logic        w_fpr_we;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        w_unused;

    // The pipeline is never back-pressured unless the hold is up; FPU/VPU share the rest.
    always_comb begin
        w_pipe_grant = !wb_hold_o && (pipe_we_i || pipe_fwe_i);
        w_fpu_pick   = fpu_valid_i && (!vpu_valid_i || !r_rr);
        w_vpu_pick   = vpu_valid_i && (!fpu_valid_i || r_rr);
        w_fpu_grant  = !rst_i && !w_pipe_grant && w_fpu_pick;
        w_vpu_grant  = !rst_i && !w_pipe_grant && w_vpu_pick;
        w_pending    = fpu_valid_i || vpu_valid_i;
    end

    assign fpu_ready_o = w_fpu_grant;
    assign vpu_ready_o = w_vpu_grant;

    always_comb begin
        w_gpr_we = 1'b0;
        w_fpr_we = 1'b0;
        w_rd     = wb_rd_o;
        w_data   = wb_data_o;
        if (w_pipe_grant) begin
            w_gpr_we = pipe_we_i;
            w_fpr_we = pipe_fwe_i;
            w_rd     = pipe_rd_i;
            w_data   = pipe_data_i;
        end else if (w_fpu_grant) begin
            w_gpr_we = !fpu_fp_i;
            w_fpr_we = fpu_fp_i;
            w_rd     = fpu_rd_i;
            w_data   = fpu_data_i;
        end else if (w_vpu_grant) begin
            w_gpr_we = 1'b1;
            w_rd     = vpu_rd_i;
            w_data   = vpu_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_rd_web_o  <= 1'b0;
            wb_frd_web_o <= 1'b0;
            wb_rd_o      <= 5'd0;
            wb_data_o    <= 32'd0;
            wb_hold_o    <= 1'b0;
            r_rr         <= 1'b0;
            r_starve_cnt <= 4'd0;
        end else begin
            // x0 writes still consume the port but never reach the GPR file.
            wb_rd_web_o  <= w_gpr_we && (w_rd != 5'd0);
            wb_frd_web_o <= w_fpr_we;
            wb_rd_o      <= w_rd;
            wb_data_o    <= w_data;
            if (w_fpu_grant || w_vpu_grant) begin
                r_rr         <= w_fpu_grant;
                r_starve_cnt <= 4'd0;
                wb_hold_o    <= 1'b0;
            end else if (w_pipe_grant && w_pending) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
                if (r_starve_cnt == STARVE_LAST) begin
                    wb_hold_o <= 1'b1;
                end
            end
        end
    end

    // rs3 only ever names an FPR, so its use flag carries no information.
    assign w_unused = id_use_fpr_i[0];

    assign id_rs1_forward_o = (id_use_fpr_i[2] ? wb_frd_web_o : wb_rd_web_o) && (wb_rd_o == id_rs1_i);
    assign id_rs2_forward_o = (id_use_fpr_i[1] ? wb_frd_web_o : wb_rd_web_o) && (wb_rd_o == id_rs2_i);
    assign id_rs3_forward_o = wb_frd_web_o && (wb_rd_o == id_rs3_i);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a rule-level reference model compared every
// cycle, plus literal expectations for the key scenarios.
module tb_wb_port_arbiter;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        pipe_we_i = 1'b0, pipe_fwe_i = 1'b0;
    logic [4:0]  pipe_rd_i = '0;
    logic [31:0] pipe_data_i = '0;
    logic        fpu_valid_i = 1'b0, fpu_fp_i = 1'b0;
    logic [4:0]  fpu_rd_i = '0;
    logic [31:0] fpu_data_i = '0;
    logic        vpu_valid_i = 1'b0;
    logic [4:0]  vpu_rd_i = '0;
    logic [31:0] vpu_data_i = '0;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, id_rs3_i = '0;
    logic [2:0]  id_use_fpr_i = '0;
    logic        fpu_ready_o, vpu_ready_o;
    logic        wb_rd_web_o, wb_frd_web_o, wb_hold_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        id_rs1_forward_o, id_rs2_forward_o, id_rs3_forward_o;

    int total = 0;
    int bad = 0;

    wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pipe_we_i(pipe_we_i), .pipe_fwe_i(pipe_fwe_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_fp_i(fpu_fp_i),
        .fpu_rd_i(fpu_rd_i), .fpu_data_i(fpu_data_i),
        .vpu_valid_i(vpu_valid_i), .vpu_ready_o(vpu_ready_o), .vpu_rd_i(vpu_rd_i), .vpu_data_i(vpu_data_i),
        .wb_rd_web_o(wb_rd_web_o), .wb_frd_web_o(wb_frd_web_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_hold_o(wb_hold_o),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs3_i(id_rs3_i), .id_use_fpr_i(id_use_fpr_i),
        .id_rs1_forward_o(id_rs1_forward_o), .id_rs2_forward_o(id_rs2_forward_o),
        .id_rs3_forward_o(id_rs3_forward_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: state as seen between clock edges.
    typedef enum {W_NONE, W_PIPE, W_FPU, W_VPU} win_t;
    bit          m_rr, m_hold, m_web, m_fweb, rst_seen;
    int          m_lost;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;

    always @(posedge rst_i) rst_seen = 1'b1;

    always @(negedge clk) begin
        win_t w;
        bit   pipe_req;
        bit   f1, f2, f3;
        if (rst_i || rst_seen) begin
            m_rr = 0; m_hold = 0; m_web = 0; m_fweb = 0; m_lost = 0; m_rd = '0; m_data = '0;
            rst_seen = 1'b0;
        end
        pipe_req = pipe_we_i || pipe_fwe_i;
        if (rst_i)                                         w = W_NONE;
        else if (!m_hold && pipe_req)                      w = W_PIPE;
        else if (fpu_valid_i && (!vpu_valid_i || !m_rr))   w = W_FPU;
        else if (vpu_valid_i)                              w = W_VPU;
        else                                               w = W_NONE;

        f1 = (id_use_fpr_i[2] ? m_fweb : m_web) && (m_rd == id_rs1_i);
        f2 = (id_use_fpr_i[1] ? m_fweb : m_web) && (m_rd == id_rs2_i);
        f3 = m_fweb && (m_rd == id_rs3_i);

        check("m_web", wb_rd_web_o, m_web);
        check("m_fweb", wb_frd_web_o, m_fweb);
        check("m_rd", wb_rd_o, m_rd);
        check("m_data", wb_data_o, m_data);
        check("m_hold", wb_hold_o, m_hold);
        check("m_fpu_ready", fpu_ready_o, w == W_FPU);
        check("m_vpu_ready", vpu_ready_o, w == W_VPU);
        check("m_fwd1", id_rs1_forward_o, f1);
        check("m_fwd2", id_rs2_forward_o, f2);
        check("m_fwd3", id_rs3_forward_o, f3);
        check("no_pipe_in_hold", m_hold && pipe_req && !rst_i, 0);

        m_web = 0;
        m_fweb = 0;
        case (w)
            W_PIPE: begin
                m_web = pipe_we_i && (pipe_rd_i != 0); m_fweb = pipe_fwe_i;
                m_rd = pipe_rd_i; m_data = pipe_data_i;
                if (fpu_valid_i || vpu_valid_i) begin
                    if (m_lost == STARVE_MAX - 1) m_hold = 1;
                    m_lost++;
                end
            end
            W_FPU: begin
                m_web = !fpu_fp_i && (fpu_rd_i != 0); m_fweb = fpu_fp_i;
                m_rd = fpu_rd_i; m_data = fpu_data_i;
                m_rr = 1; m_lost = 0; m_hold = 0;
            end
            W_VPU: begin
                m_web = (vpu_rd_i != 0);
                m_rd = vpu_rd_i; m_data = vpu_data_i;
                m_rr = 0; m_lost = 0; m_hold = 0;
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic fpu_put(input bit fp, input logic [4:0] rd, input logic [31:0] d);
        bit got = 0;
        fpu_fp_i = fp; fpu_rd_i = rd; fpu_data_i = d; fpu_valid_i = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = fpu_ready_o;
            tick();
        end
        fpu_valid_i = 1'b0;
        check("fpu_handshake", got, 1);
    endtask

    task automatic vpu_put(input logic [4:0] rd, input logic [31:0] d);
        bit got = 0;
        vpu_rd_i = rd; vpu_data_i = d; vpu_valid_i = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = vpu_ready_o;
            tick();
        end
        vpu_valid_i = 1'b0;
        check("vpu_handshake", got, 1);
    endtask

    // Pipeline GPR writes every cycle, backing off while the hold is up.
    task automatic pipe_run(input int n, input logic [4:0] rd0);
        for (int i = 0; i < n; i++) begin
            if (!m_hold) begin
                pipe_we_i = 1'b1; pipe_rd_i = 5'(rd0 + i); pipe_data_i = 32'h100 + i;
            end else begin
                pipe_we_i = 1'b0;
            end
            tick();
        end
        pipe_we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Pipeline GPR write and forward to rs1
        pipe_we_i = 1'b1; pipe_rd_i = 5'd5; pipe_data_i = 32'hDEADBEEF;
        tick();
        pipe_we_i = 1'b0; id_rs1_i = 5'd5; id_rs2_i = 5'd5; id_rs3_i = 5'd5; id_use_fpr_i = 3'b010;
        #2;
        check("A_web", wb_rd_web_o, 1);
        check("A_rd", wb_rd_o, 5);
        check("A_data", wb_data_o, 32'hDEADBEEF);
        check("A_fwd1", id_rs1_forward_o, 1);
        check("A_fwd2_fpr", id_rs2_forward_o, 0);
        check("A_fwd3", id_rs3_forward_o, 0);
        tick();
        #2;
        check("A_idle_web", wb_rd_web_o, 0);
        check("A_idle_rd", wb_rd_o, 5);
        check("A_idle_data", wb_data_o, 32'hDEADBEEF);
        id_rs1_i = '0; id_rs2_i = '0; id_rs3_i = '0; id_use_fpr_i = '0;

        // FPU and VPU both valid from reset: FPU, VPU, FPU
        do_reset();
        fork
            begin fpu_put(1'b0, 5'd7, 32'h11); fpu_put(1'b1, 5'd9, 32'h33); end
            vpu_put(5'd8, 32'h22);
            begin
                #2;  check("B_c1_fr", fpu_ready_o, 1); check("B_c1_vr", vpu_ready_o, 0);
                #10; check("B_c2_fr", fpu_ready_o, 0); check("B_c2_vr", vpu_ready_o, 1);
                     check("B_c2_web", wb_rd_web_o, 1); check("B_c2_rd", wb_rd_o, 7);
                #10; check("B_c3_fr", fpu_ready_o, 1); check("B_c3_vr", vpu_ready_o, 0);
                     check("B_c3_rd", wb_rd_o, 8); check("B_c3_data", wb_data_o, 32'h22);
                #10; check("B_c4_fweb", wb_frd_web_o, 1); check("B_c4_rd", wb_rd_o, 9);
            end
        join
        tick();

        // VPU starved by the pipeline until the hold rises
        do_reset();
        fork
            pipe_run(8, 5'd10);
            vpu_put(5'd4, 32'h55);
            begin
                #2;  check("C_c1_hold", wb_hold_o, 0); check("C_c1_vr", vpu_ready_o, 0);
                #30; check("C_c4_hold", wb_hold_o, 0); check("C_c4_vr", vpu_ready_o, 0);
                #10; check("C_c5_hold", wb_hold_o, 1); check("C_c5_vr", vpu_ready_o, 1);
                     check("C_c5_rd", wb_rd_o, 13);
                #10; check("C_c6_hold", wb_hold_o, 0); check("C_c6_rd", wb_rd_o, 4);
                     check("C_c6_data", wb_data_o, 32'h55);
            end
        join
        tick();

        // FPU FPR write does not forward to a GPR read of the same index
        id_rs1_i = 5'd3; id_rs2_i = 5'd3; id_rs3_i = 5'd3; id_use_fpr_i = 3'b000;
        fork
            fpu_put(1'b1, 5'd3, 32'h3F800000);
            begin
                #2;  check("D_fr", fpu_ready_o, 1);
                #10; check("D_fweb", wb_frd_web_o, 1); check("D_web", wb_rd_web_o, 0);
                     check("D_fwd1_gpr", id_rs1_forward_o, 0); check("D_fwd3", id_rs3_forward_o, 1);
                id_use_fpr_i = 3'b100;
                #1;  check("D_fwd1_fpr", id_rs1_forward_o, 1);
            end
        join
        tick();

        // VPU write to x0 handshakes but is discarded
        fork
            vpu_put(5'd0, 32'hABCD);
            begin
                #2;  check("E_vr", vpu_ready_o, 1);
                #10; check("E_web", wb_rd_web_o, 0); check("E_fweb", wb_frd_web_o, 0);
            end
        join
        tick();

        // Asynchronous reset pulse while hold is up and the FPU is valid
        do_reset();
        id_rs1_i = 5'd13; id_rs2_i = 5'd0; id_rs3_i = 5'd0; id_use_fpr_i = 3'b000;
        fork
            pipe_run(8, 5'd10);
            fpu_put(1'b0, 5'd6, 32'h66);
            begin
                #2;  check("F_c1_fr", fpu_ready_o, 0);
                #39; check("F_pre_hold", wb_hold_o, 1); check("F_pre_fr", fpu_ready_o, 1);
                     check("F_pre_fwd1", id_rs1_forward_o, 1);
                rst_i = 1'b1;
                #1;  check("F_rst_hold", wb_hold_o, 0); check("F_rst_fr", fpu_ready_o, 0);
                     check("F_rst_vr", vpu_ready_o, 0); check("F_rst_web", wb_rd_web_o, 0);
                     check("F_rst_fweb", wb_frd_web_o, 0); check("F_rst_rd", wb_rd_o, 0);
                     check("F_rst_data", wb_data_o, 0); check("F_rst_fwd1", id_rs1_forward_o, 0);
                     check("F_rst_fwd2", id_rs2_forward_o, 0); check("F_rst_fwd3", id_rs3_forward_o, 0);
                rst_i = 1'b0;
                #1;  check("F_rel_fr", fpu_ready_o, 1); check("F_rel_web", wb_rd_web_o, 0);
                #8;  check("F_c6_web", wb_rd_web_o, 1); check("F_c6_rd", wb_rd_o, 6);
                     check("F_c6_data", wb_data_o, 32'h66); check("F_c6_hold", wb_hold_o, 0);
            end
        join
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
